// File: rtl/pong_game_core.sv
// Pong engine: paddles, ball, scoring FSM and a 1-cycle pixel colour path.
// Define CENTER_NET_EN to draw the dashed centre net.
module pong_game_core #(
   parameter int H_RES        = 640,
   parameter int V_RES        = 480,
   parameter int PADDLE_H     = 80,
   parameter int PADDLE_W     = 3,
   parameter int LEFT_X       = 24,
   parameter int RIGHT_X      = 614,
   parameter int BALL_SIZE    = 4,
   parameter int BALL_SPEED   = 2,
   parameter int PADDLE_SPEED = 4,
   parameter int SERVE_FRAMES = 60,
   parameter int WIN_SCORE    = 9,
   parameter int SCORE_W      = 4,
   parameter int COLOR_W      = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_tick,
   input  logic               left_up,
   input  logic               left_down,
   input  logic               right_up,
   input  logic               right_down,
   input  logic [9:0]         px_x,
   input  logic [9:0]         px_y,
   input  logic               px_active,
   output logic [COLOR_W-1:0] r,
   output logic [COLOR_W-1:0] g,
   output logic [COLOR_W-1:0] b,
   output logic [SCORE_W-1:0] left_score,
   output logic [SCORE_W-1:0] right_score,
   output logic               game_over
);

   typedef enum logic [1:0] {SERVE, PLAY, POINT, OVER} state_t;
   typedef logic signed [10:0] s11_t;

   localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

   localparam s11_t HALF_PH    = s11_t'(PADDLE_H / 2);
   localparam s11_t PAD_MAX    = s11_t'(V_RES - PADDLE_H / 2);
   localparam s11_t SPEED_P    = s11_t'(PADDLE_SPEED);
   localparam s11_t SPEED_B    = s11_t'(BALL_SPEED);
   localparam s11_t SIZE_B     = s11_t'(BALL_SIZE);
   localparam s11_t LEFT_EDGE  = s11_t'(LEFT_X + PADDLE_W);
   localparam s11_t RIGHT_EDGE = s11_t'(RIGHT_X - BALL_SIZE);
   localparam s11_t H_MAX      = s11_t'(H_RES);
   localparam s11_t V_MAX      = s11_t'(V_RES);

   localparam logic [9:0] BX0    = 10'(H_RES / 2 - BALL_SIZE / 2);
   localparam logic [9:0] BY0    = 10'(V_RES / 2 - BALL_SIZE / 2);
   localparam logic [9:0] PC0    = 10'(V_RES / 2);
   localparam logic [9:0] BY_MAX = 10'(V_RES - BALL_SIZE);

   localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
   localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
   localparam logic [COLOR_W-1:0] FULL       = '1;

   state_t             state;
   logic [CNT_W-1:0]   serveCnt;
   logic [SCORE_W-1:0] leftScore;
   logic [SCORE_W-1:0] rightScore;
   logic [9:0]         leftC;
   logic [9:0]         rightC;
   logic [9:0]         ballX;
   logic [9:0]         ballY;
   logic               dxRight;
   logic               dyDown;
   logic               leftScoredLast;
   logic               gameOverQ;

   function automatic logic [9:0] movePaddle(
      input logic [9:0] c,
      input logic       up,
      input logic       dn
   );
      s11_t v;
      v = $signed({1'b0, c});
      if (up && !dn) begin
         v = v - SPEED_P;
         if (v < HALF_PH) v = HALF_PH;
      end else if (dn && !up) begin
         v = v + SPEED_P;
         if (v > PAD_MAX) v = PAD_MAX;
      end
      return v[9:0];
   endfunction

   function automatic logic rowsHit(input s11_t y, input logic [9:0] c);
      s11_t top;
      top = $signed({1'b0, c}) - HALF_PH;
      return (y <= top + s11_t'(PADDLE_H) - 11'sd1)
          && (y + SIZE_B - 11'sd1 >= top);
   endfunction

   function automatic logic inRect(
      input s11_t px,
      input s11_t py,
      input s11_t x0,
      input s11_t y0,
      input s11_t w,
      input s11_t h
   );
      return (px >= x0) && (px < x0 + w)
          && (py >= y0) && (py < y0 + h);
   endfunction

   s11_t       bxS;
   s11_t       byS;
   logic [9:0] xNext;
   logic [9:0] yNext;
   logic       dxNext;
   logic       dyNext;
   logic       leftScores;
   logic       rightScores;

   assign bxS = $signed({1'b0, ballX});
   assign byS = $signed({1'b0, ballY});

   // One PLAY step; each axis is resolved on its own.
   always_comb begin
      yNext  = ballY;
      dyNext = dyDown;
      if (dyDown) begin
         if (byS + SIZE_B + SPEED_B > V_MAX) begin
            yNext  = BY_MAX;
            dyNext = 1'b0;
         end else begin
            yNext = 10'(byS + SPEED_B);
         end
      end else begin
         if (byS < SPEED_B) begin
            yNext  = '0;
            dyNext = 1'b1;
         end else begin
            yNext = 10'(byS - SPEED_B);
         end
      end

      xNext       = ballX;
      dxNext      = dxRight;
      leftScores  = 1'b0;
      rightScores = 1'b0;
      if (dxRight) begin
         if (bxS <= RIGHT_EDGE && bxS + SPEED_B > RIGHT_EDGE
             && rowsHit(byS, rightC)) begin
            xNext  = RIGHT_EDGE[9:0];
            dxNext = 1'b0;
         end else if (bxS + SIZE_B + SPEED_B > H_MAX) begin
            leftScores = 1'b1;
         end else begin
            xNext = 10'(bxS + SPEED_B);
         end
      end else begin
         if (bxS >= LEFT_EDGE && bxS - SPEED_B < LEFT_EDGE
             && rowsHit(byS, leftC)) begin
            xNext  = LEFT_EDGE[9:0];
            dxNext = 1'b1;
         end else if (bxS < SPEED_B) begin
            rightScores = 1'b1;
         end else begin
            xNext = 10'(bxS - SPEED_B);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= SERVE;
         serveCnt       <= '0;
         leftScore      <= '0;
         rightScore     <= '0;
         leftC          <= PC0;
         rightC         <= PC0;
         ballX          <= BX0;
         ballY          <= BY0;
         dxRight        <= 1'b1;
         dyDown         <= 1'b1;
         leftScoredLast <= 1'b0;
         gameOverQ      <= 1'b0;
      end else if (frame_tick) begin
         if (state != OVER) begin
            leftC  <= movePaddle(leftC, left_up, left_down);
            rightC <= movePaddle(rightC, right_up, right_down);
         end
         unique case (state)
            SERVE: begin
               if (serveCnt == SERVE_LAST) begin
                  serveCnt <= '0;
                  state    <= PLAY;
               end else begin
                  serveCnt <= serveCnt + 1'b1;
               end
            end
            PLAY: begin
               ballY  <= yNext;
               dyDown <= dyNext;
               if (leftScores) begin
                  if (leftScore != WIN) leftScore <= leftScore + 1'b1;
                  leftScoredLast <= 1'b1;
                  state          <= POINT;
               end else if (rightScores) begin
                  if (rightScore != WIN) rightScore <= rightScore + 1'b1;
                  leftScoredLast <= 1'b0;
                  state          <= POINT;
               end else begin
                  ballX   <= xNext;
                  dxRight <= dxNext;
               end
            end
            POINT: begin
               if (leftScore == WIN || rightScore == WIN) begin
                  state     <= OVER;
                  gameOverQ <= 1'b1;
               end else begin
                  // Serve toward whoever just conceded.
                  ballX    <= BX0;
                  ballY    <= BY0;
                  dxRight  <= leftScoredLast;
                  serveCnt <= '0;
                  state    <= SERVE;
               end
            end
            OVER: begin
               if (left_up || right_up) begin
                  leftScore  <= '0;
                  rightScore <= '0;
                  ballX      <= BX0;
                  ballY      <= BY0;
                  dxRight    <= 1'b1;
                  serveCnt   <= '0;
                  gameOverQ  <= 1'b0;
                  state      <= SERVE;
               end
            end
            default: state <= SERVE;
         endcase
      end
   end

   s11_t               pxS;
   s11_t               pyS;
   logic               onObj;
   logic [COLOR_W-1:0] pixel;

   assign pxS = $signed({1'b0, px_x});
   assign pyS = $signed({1'b0, px_y});

   assign onObj =
      inRect(pxS, pyS, s11_t'(LEFT_X),
             $signed({1'b0, leftC}) - HALF_PH,
             s11_t'(PADDLE_W), s11_t'(PADDLE_H))
      || inRect(pxS, pyS, s11_t'(RIGHT_X),
             $signed({1'b0, rightC}) - HALF_PH,
             s11_t'(PADDLE_W), s11_t'(PADDLE_H))
      || inRect(pxS, pyS, bxS, byS, SIZE_B, SIZE_B);

`ifdef CENTER_NET_EN
   localparam s11_t H_MID = s11_t'(H_RES / 2);
   localparam logic [COLOR_W-1:0] NET = {1'b1, {(COLOR_W-1){1'b0}}};
   logic onNet;
   assign onNet = (pxS == H_MID - 11'sd1 || pxS == H_MID) && !px_y[4];

   always_comb begin
      pixel = '0;
      if (px_active) begin
         if (onObj)      pixel = FULL;
         else if (onNet) pixel = NET;
      end
   end
`else
   always_comb begin
      pixel = '0;
      if (px_active && onObj) pixel = FULL;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r <= '0;
         g <= '0;
         b <= '0;
      end else begin
         r <= pixel;
         g <= pixel;
         b <= pixel;
      end
   end

   assign left_score  = leftScore;
   assign right_score = rightScore;
   assign game_over   = gameOverQ;

endmodule

// File: tb/tb_pong_game_core.sv
// Directed bench for pong_game_core: pixel probe table plus
// hand-timed serve, bounce, hit, miss and game-over sequences.
module tb_pong_game_core;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       frame_tick;
   logic       left_up, left_down, right_up, right_down;
   logic [9:0] px_x, px_y;
   logic       px_active;
   logic [3:0] r, g, b;
   logic [3:0] left_score, right_score;
   logic       game_over;

   always #5 clk = ~clk;

   pong_game_core dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_tick  (frame_tick),
      .left_up     (left_up),
      .left_down   (left_down),
      .right_up    (right_up),
      .right_down  (right_down),
      .px_x        (px_x),
      .px_y        (px_y),
      .px_active   (px_active),
      .r           (r),
      .g           (g),
      .b           (b),
      .left_score  (left_score),
      .right_score (right_score),
      .game_over   (game_over)
   );

   typedef struct {
      logic [9:0] x;
      logic [9:0] y;
      logic       act;
      logic [3:0] colour;
      string      name;
   } pix_t;

   pix_t vec[$];
   int   nChecks = 0;
   int   nFail   = 0;

   task automatic check(input string name, input int got, input int want);
      nChecks++;
      if (got != want) begin
         nFail++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   task automatic add(input int x, input int y, input logic act,
                      input logic [3:0] col, input string name);
      pix_t p;
      p.x = 10'(x);
      p.y = 10'(y);
      p.act = act;
      p.colour = col;
      p.name = name;
      vec.push_back(p);
   endtask

   task automatic tick(input logic lu, input logic ld,
                       input logic ru, input logic rd);
      @(negedge clk);
      left_up = lu;
      left_down = ld;
      right_up = ru;
      right_down = rd;
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      left_up = 1'b0;
      left_down = 1'b0;
      right_up = 1'b0;
      right_down = 1'b0;
   endtask

   task automatic probe(input int x, input int y, input logic act,
                        input logic [3:0] want, input string name);
      @(negedge clk);
      px_x = 10'(x);
      px_y = 10'(y);
      px_active = act;
      @(negedge clk);
      check(name, int'({r, g, b}), int'({want, want, want}));
   endtask

   task automatic rally(input int target, input logic ru,
                        input logic rd, input int budget);
      int n = 0;
      while (left_score != 4'(target) && n < budget) begin
         tick(1'b0, 1'b0, ru, rd);
         n++;
      end
      check($sformatf("rally%0d_left", target), int'(left_score), target);
      check($sformatf("rally%0d_right", target), int'(right_score), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      frame_tick = 1'b0;
      left_up = 1'b0;
      left_down = 1'b0;
      right_up = 1'b0;
      right_down = 1'b0;
      px_x = '0;
      px_y = '0;
      px_active = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_rgb", int'({r, g, b}), 0);
      check("rst_go", int'(game_over), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_left", int'(left_score), 0);
      check("idle_right", int'(right_score), 0);
      check("idle_go", int'(game_over), 0);
      check("idle_rgb", int'({r, g, b}), 0);

      add(318, 238, 1'b1, 4'hF, "ball_tl");
      add(321, 241, 1'b1, 4'hF, "ball_br");
      add(317, 238, 1'b1, 4'h0, "ball_left_out");
      add(322, 241, 1'b1, 4'h0, "ball_right_out");
      add(318, 237, 1'b1, 4'h0, "ball_top_out");
      add(318, 242, 1'b1, 4'h0, "ball_bot_out");
      add(25, 240, 1'b1, 4'hF, "lpad_mid");
      add(25, 240, 1'b0, 4'h0, "lpad_blank");
      add(24, 200, 1'b1, 4'hF, "lpad_top");
      add(26, 279, 1'b1, 4'hF, "lpad_bot");
      add(25, 199, 1'b1, 4'h0, "lpad_above");
      add(25, 280, 1'b1, 4'h0, "lpad_below");
      add(23, 240, 1'b1, 4'h0, "lpad_leftcol");
      add(27, 240, 1'b1, 4'h0, "lpad_rightcol");
      add(614, 200, 1'b1, 4'hF, "rpad_top");
      add(616, 279, 1'b1, 4'hF, "rpad_bot");
      add(613, 240, 1'b1, 4'h0, "rpad_leftcol");
      add(617, 240, 1'b1, 4'h0, "rpad_rightcol");
      add(319, 100, 1'b1, 4'h0, "net_col_a");
      add(320, 96, 1'b1, 4'h0, "net_col_b");
      for (int i = 0; i < vec.size(); i++)
         probe(vec[i].x, vec[i].y, vec[i].act, vec[i].colour, vec[i].name);

      // Serve hold with left paddle pinned at the top.
      repeat (60) tick(1'b1, 1'b0, 1'b0, 1'b0);
      probe(25, 0, 1'b1, 4'hF, "lsat_top");
      probe(25, 79, 1'b1, 4'hF, "lsat_top_end");
      probe(25, 80, 1'b1, 4'h0, "lsat_top_below");
      probe(318, 238, 1'b1, 4'hF, "serve_hold");
      probe(614, 240, 1'b1, 4'hF, "rpad_still");

      repeat (100) tick(1'b0, 1'b1, 1'b0, 1'b1);
      probe(25, 479, 1'b1, 4'hF, "lsat_bot");
      probe(25, 400, 1'b1, 4'hF, "lsat_bot_top");
      probe(25, 399, 1'b1, 4'h0, "lsat_bot_above");
      probe(615, 479, 1'b1, 4'hF, "rsat_bot");
      probe(615, 399, 1'b1, 4'h0, "rsat_bot_above");
      probe(518, 438, 1'b1, 4'hF, "ball_t100");
      probe(517, 438, 1'b1, 4'h0, "ball_t100_l");
      probe(522, 438, 1'b1, 4'h0, "ball_t100_r");

      repeat (5) tick(1'b1, 1'b1, 1'b0, 1'b0);
      probe(25, 400, 1'b1, 4'hF, "both_hold");
      probe(25, 399, 1'b1, 4'h0, "both_hold_above");
      probe(528, 448, 1'b1, 4'hF, "ball_t105");

      repeat (14) tick(1'b0, 1'b0, 1'b0, 1'b0);
      probe(556, 476, 1'b1, 4'hF, "ball_floor");
      probe(556, 479, 1'b1, 4'hF, "ball_floor_bot");
      probe(556, 475, 1'b1, 4'h0, "ball_floor_above");
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      probe(558, 476, 1'b1, 4'hF, "floor_clamp");
      probe(558, 475, 1'b1, 4'h0, "floor_clamp_above");
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      probe(560, 474, 1'b1, 4'hF, "dy_flipped");
      probe(560, 478, 1'b1, 4'h0, "dy_flipped_below");

      // Right paddle (rows 400..479) returns the ball.
      repeat (26) tick(1'b0, 1'b0, 1'b0, 1'b0);
      probe(610, 422, 1'b1, 4'hF, "rhit_clamp");
      probe(609, 422, 1'b1, 4'h0, "rhit_clamp_l");
      check("rhit_left", int'(left_score), 0);
      check("rhit_right", int'(right_score), 0);
      tick(1'b1, 1'b0, 1'b1, 0);
      probe(608, 420, 1'b1, 4'hF, "rhit_dx_left");
      probe(612, 420, 1'b1, 4'h0, "rhit_dx_left_r");

      // Left paddle to 192 to catch the return, right paddle to 40.
      repeat (61) tick(1'b1, 1'b0, 1'b1, 1'b0);
      rally(1, 1'b1, 1'b0, 800);
      check("point_go", int'(game_over), 0);
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      probe(318, 238, 1'b1, 4'hF, "point_recentre");
      probe(322, 238, 1'b1, 4'h0, "point_recentre_r");
      rally(2, 1'b0, 1'b1, 400);
      for (int k = 3; k <= 9; k++)
         rally(k, (k % 2) == 1, (k % 2) == 0, 400);

      check("win_point_go", int'(game_over), 0);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      check("over_go", int'(game_over), 1);
      check("over_left", int'(left_score), 9);
      check("over_right", int'(right_score), 0);
      repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b1);
      check("over_hold_go", int'(game_over), 1);
      probe(25, 152, 1'b1, 4'hF, "over_frozen_top");
      probe(25, 232, 1'b1, 4'h0, "over_frozen_below");

      tick(1'b1, 1'b0, 1'b0, 1'b0);
      check("restart_go", int'(game_over), 0);
      check("restart_left", int'(left_score), 0);
      check("restart_right", int'(right_score), 0);
      probe(318, 238, 1'b1, 4'hF, "restart_ball");
      probe(25, 152, 1'b1, 4'hF, "restart_pad");
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      probe(318, 238, 1'b1, 4'hF, "restart_serve");

      $display("End of test - %0d assertions evaluated, %0d failures",
               nChecks, nFail);
      $finish;
   end

endmodule
